// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Brief   : Shared types and default geometry for the VGA framebuffer path.
// Rev     : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default display geometry; one 16-bit word holds two pixels.
  localparam int H_RES              = 640;
  localparam int V_RES              = 480;
  localparam int DEF_WORDS_PER_LINE = H_RES / 2;
  localparam int LINE_NUM_W         = $clog2(V_RES);

  // Default framebuffer bus geometry.
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vga_fb_arbiter
// Brief  : Shares the single-port framebuffer SRAM between line fetches into
//          an external line buffer and CPU writes, with a bounded CPU wait
//          during a fetch.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int CPU_SLOT       = 8
) (
  input  logic                              CLOCK_50,
  input  logic                              RESET_N,
  input  logic                              LINE_REQ,
  input  logic [LINE_NUM_W-1:0]             LINE_NUM,
  input  logic                              CPU_REQ,
  input  logic [ADDR_W-1:0]                 CPU_ADDR,
  input  logic [DATA_W-1:0]                 CPU_WDATA,
  output logic                              CPU_ACK,
  output logic [ADDR_W-1:0]                 MEM_ADDR,
  output logic [DATA_W-1:0]                 MEM_WDATA,
  output logic                              MEM_WE,
  output logic                              MEM_RE,
  input  logic [DATA_W-1:0]                 MEM_RDATA,
  output logic                              LB_WE,
  output logic [$clog2(WORDS_PER_LINE)-1:0] LB_ADDR,
  output logic [DATA_W-1:0]                 LB_WDATA,
  output logic                              FETCH_BUSY,
  output logic                              UNDERRUN
);

  localparam int LB_AW  = $clog2(WORDS_PER_LINE);
  localparam int WAIT_W = $clog2(CPU_SLOT + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [LB_AW-1:0]    r_rd_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_mem_re;
  logic                r_mem_we;
  logic                r_cpu_ack;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [LB_AW-1:0]    r_re_idx;
  logic                r_lb_we;
  logic [LB_AW-1:0]    r_lb_addr;
  logic                r_underrun;

  logic                w_cpu_pend;
  logic                w_last_rd;
  logic                w_slot_due;
  logic                w_issue_rd;
  logic                w_grant;
  logic                w_line_start;

  // A request seen while its own ACK is still high is the tail of the last write.
  assign w_cpu_pend   = CPU_REQ & ~r_cpu_ack;
  assign w_last_rd    = (r_rd_cnt == LB_AW'(WORDS_PER_LINE - 1));
  assign w_slot_due   = (r_wait_cnt == WAIT_W'(CPU_SLOT));
  assign w_line_start = (r_state == ST_IDLE) & LINE_REQ;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: FETCH ends on the edge that issues the last read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (LINE_REQ) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_issue_rd && w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot decision: a line request beats the CPU in IDLE; in FETCH the CPU
  // only takes a slot once it has waited out CPU_SLOT reads.
  always_comb begin
    w_issue_rd = 1'b0;
    w_grant    = 1'b0;
    case (r_state)
      ST_IDLE:  w_grant = w_cpu_pend & ~LINE_REQ;
      ST_FETCH: begin
        if (w_cpu_pend && w_slot_due) w_grant    = 1'b1;
        else                          w_issue_rd = 1'b1;
      end
      ST_DRAIN: w_grant = w_cpu_pend;
      default:  w_grant = 1'b0;
    endcase
  end

  // Fetch counters: base latched on acceptance, read index and CPU wait count.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_base     <= '0;
      r_rd_cnt   <= '0;
      r_wait_cnt <= '0;
    end else if (w_line_start) begin
      r_base     <= ADDR_W'(32'(LINE_NUM) * 32'(WORDS_PER_LINE));
      r_rd_cnt   <= '0;
      r_wait_cnt <= '0;
    end else if (w_issue_rd) begin
      r_rd_cnt <= w_last_rd ? '0 : r_rd_cnt + 1'b1;
      if (w_cpu_pend && !w_slot_due) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else if (w_grant) begin
      r_wait_cnt <= '0;
    end
  end

  // Registered SRAM command, CPU ACK and the one-stage line-buffer pipeline.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_re_idx    <= '0;
      r_lb_we     <= 1'b0;
      r_lb_addr   <= '0;
    end else begin
      r_mem_re  <= w_issue_rd;
      r_mem_we  <= w_grant;
      r_cpu_ack <= w_grant;
      if (w_issue_rd) begin
        r_mem_addr <= r_base + ADDR_W'(r_rd_cnt);
        r_re_idx   <= r_rd_cnt;
      end else if (w_grant) begin
        r_mem_addr  <= CPU_ADDR;
        r_mem_wdata <= CPU_WDATA;
      end
      r_lb_we   <= r_mem_re;
      r_lb_addr <= r_re_idx;
    end
  end

  // Sticky underrun: a line request while busy is dropped and remembered.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                           r_underrun <= 1'b0;
    else if (LINE_REQ && r_state != ST_IDLE) r_underrun <= 1'b1;
  end

  assign CPU_ACK    = r_cpu_ack;
  assign MEM_ADDR   = r_mem_addr;
  assign MEM_WDATA  = r_mem_wdata;
  assign MEM_WE     = r_mem_we;
  assign MEM_RE     = r_mem_re;
  assign LB_WE      = r_lb_we;
  assign LB_ADDR    = r_lb_addr;
  assign LB_WDATA   = MEM_RDATA;
  assign FETCH_BUSY = (r_state != ST_IDLE) | r_lb_we;
  assign UNDERRUN   = r_underrun;

endmodule : vga_fb_arbiter
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_fb_arbiter
// Brief  : Directed self-checking bench for vga_fb_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  localparam int WPL = 320;
  localparam logic [15:0] KEY = 16'h5A3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_req;
  logic [8:0]  line_num;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        lb_we;
  logic [8:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        fetch_busy;
  logic        underrun;

  int   checks = 0;
  int   errors = 0;
  logic exp_unr;

  vga_fb_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(WPL), .CPU_SLOT(8)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .LINE_REQ(line_req), .LINE_NUM(line_num),
    .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata), .CPU_ACK(cpu_ack),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we), .MEM_RE(mem_re),
    .MEM_RDATA(mem_rdata), .LB_WE(lb_we), .LB_ADDR(lb_addr), .LB_WDATA(lb_wdata),
    .FETCH_BUSY(fetch_busy), .UNDERRUN(underrun)
  );

  always #5 clk = ~clk;

  // SRAM model: content is address XOR KEY, data valid the cycle after MEM_RE.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_addr ^ KEY;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re"},    32'(mem_re),     32'd0);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_ack"},   32'(cpu_ack),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),   32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
    check({tag, "_lbwe"},  32'(lb_we),      32'd0);
    check({tag, "_lbadr"}, 32'(lb_addr),    32'd0);
    check({tag, "_busy"},  32'(fetch_busy), 32'd0);
    check({tag, "_unr"},   32'(underrun),   32'd0);
  endtask

  // One line fetch. base is the hand-computed first address; cpu_c is the
  // cycle the CPU request is raised (0 = together with LINE_REQ, -1 = none);
  // wr_c is the hand-computed cycle of the CPU write (0 = none); dup_c is the
  // cycle a second LINE_REQ is raised (-1 = none). Cycle c means just after
  // rising edge c, with edge 0 the one sampling LINE_REQ.
  task automatic run_fetch(input logic [8:0] line, input logic [15:0] base,
                           input int cpu_c, input int wr_c, input int dup_c);
    int          ext;
    int          idx;
    logic [15:0] a;
    ext      = (wr_c > 0) ? 1 : 0;
    line_num = line;
    line_req = 1'b1;
    if (cpu_c == 0) cpu_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    check("busy_rise", 32'(fetch_busy), 32'd1);
    check("re_latency", 32'(mem_re), 32'd0);
    check("line_wins", 32'(cpu_ack), 32'd0);
    for (int c = 1; c <= WPL + 2 + ext; c++) begin
      @(negedge clk);
      if (c <= WPL + ext) begin
        if (c == wr_c) begin
          check("wr_we",    32'(mem_we),    32'd1);
          check("wr_ack",   32'(cpu_ack),   32'd1);
          check("wr_re",    32'(mem_re),    32'd0);
          check("wr_addr",  32'(mem_addr),  32'(cpu_addr));
          check("wr_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        end else begin
          idx = c - 1 - ((wr_c > 0 && c > wr_c) ? 1 : 0);
          a   = base + 16'(idx);
          check("rd_re",   32'(mem_re),   32'd1);
          check("rd_we",   32'(mem_we),   32'd0);
          check("rd_addr", 32'(mem_addr), 32'(a));
        end
      end else begin
        check("tail_re", 32'(mem_re), 32'd0);
        check("tail_we", 32'(mem_we), 32'd0);
      end
      if (c >= 2 && c <= WPL + 1 + ext && !(wr_c > 0 && c == wr_c + 1)) begin
        idx = c - 2 - ((wr_c > 0 && c > wr_c + 1) ? 1 : 0);
        a   = base + 16'(idx);
        check("lb_we",    32'(lb_we),    32'd1);
        check("lb_addr",  32'(lb_addr),  32'(idx));
        check("lb_wdata", 32'(lb_wdata), 32'(a ^ KEY));
      end else begin
        check("lb_idle", 32'(lb_we), 32'd0);
      end
      check("busy", 32'(fetch_busy), (c <= WPL + 1 + ext) ? 32'd1 : 32'd0);
      if (dup_c > 0 && c == dup_c + 1) exp_unr = 1'b1;
      check("underrun", 32'(underrun), 32'(exp_unr));
      if (c == cpu_c) cpu_req = 1'b1;
      if (c == wr_c)  cpu_req = 1'b0;
      line_req = (dup_c > 0 && c == dup_c);
      if (dup_c > 0 && c == dup_c) line_num = 9'd7;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    line_req  = 1'b0;
    line_num  = '0;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    exp_unr   = 1'b0;
    mem_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(fetch_busy), 32'd0);

    // Uncontended line 2: addresses 640..959.
    run_fetch(9'd2, 16'd640, -1, 0, -1);
    repeat (3) @(negedge clk);

    // CPU write in IDLE, held request gives a write every other cycle.
    cpu_addr  = 16'h1234;
    cpu_wdata = 16'hBEEF;
    cpu_req   = 1'b1;
    @(negedge clk);
    check("idle_ack",   32'(cpu_ack),   32'd1);
    check("idle_we",    32'(mem_we),    32'd1);
    check("idle_re",    32'(mem_re),    32'd0);
    check("idle_addr",  32'(mem_addr),  32'h1234);
    check("idle_wdata", 32'(mem_wdata), 32'hBEEF);
    @(negedge clk);
    check("idle_gap_ack", 32'(cpu_ack), 32'd0);
    check("idle_gap_we",  32'(mem_we),  32'd0);
    @(negedge clk);
    check("idle_ack2",  32'(cpu_ack),  32'd1);
    check("idle_addr2", 32'(mem_addr), 32'h1234);
    cpu_req = 1'b0;
    @(negedge clk);
    check("idle_ack_off", 32'(cpu_ack), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_quiet", 32'(cpu_ack), 32'd0);

    // CPU request raised mid-fetch at cycle 10: reads at 11..18, write at 19.
    cpu_addr  = 16'h00AA;
    cpu_wdata = 16'h1357;
    run_fetch(9'd1, 16'd320, 10, 19, -1);
    repeat (2) @(negedge clk);

    // LINE_REQ during a fetch sets UNDERRUN; the fetch is unchanged.
    run_fetch(9'd3, 16'd960, -1, 0, 50);
    repeat (2) @(negedge clk);
    check("unr_sticky", 32'(underrun), 32'd1);
    // A later request in IDLE is accepted normally.
    run_fetch(9'd4, 16'd1280, -1, 0, -1);
    repeat (2) @(negedge clk);

    // Line 479: 153280 wraps to 22208; CPU request together with LINE_REQ.
    cpu_addr  = 16'h4321;
    cpu_wdata = 16'hCAFE;
    run_fetch(9'd479, 16'd22208, 0, 9, -1);
    repeat (2) @(negedge clk);

    // Line 204: base 65280, read addresses wrap past 0xFFFF to 0..63.
    run_fetch(9'd204, 16'd65280, -1, 0, -1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a fetch.
    line_num = 9'd2;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    repeat (101) @(negedge clk);
    check("pre_rst_re",   32'(mem_re),   32'd1);
    check("pre_rst_addr", 32'(mem_addr), 32'd740);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_unr = 1'b0;
    @(negedge clk);
    run_fetch(9'd5, 16'd1600, -1, 0, -1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vga_fb_arbiter
`default_nettype wire
